// File: rtl/demux_1_to_2_32bit_reg_pkg.sv
// demux_1_to_2_32bit_reg_pkg: shared widths, select codes and channel state
// encoding for the registered 1-to-2 demux.
package demux_1_to_2_32bit_reg_pkg;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } ch_state_e;
endpackage

// File: rtl/demux_out_reg.sv
// demux_out_reg: single-entry valid/ready output register; free means it can
// take a load this cycle (empty, or its word is draining).
module demux_out_reg
   import demux_1_to_2_32bit_reg_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         x_ready,
   output logic         x_valid,
   output logic [W-1:0] x_data,
   output logic         free
);
   ch_state_e    state_q, state_d;
   logic [W-1:0] data_q, data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // Loads only arrive while free, so a load always wins over the drain.
   always_comb begin
      state_d = load ? FULL : (x_ready ? EMPTY : state_q);
      data_d  = load ? load_data : data_q;
   end

   assign x_valid = state_q == FULL;
   assign x_data  = data_q;
   assign free    = state_q == EMPTY || x_ready;
endmodule

// File: rtl/demux_1_to_2_32bit_reg.sv
// demux_1_to_2_32bit_reg: routes each accepted word to output A or B through
// a registered valid/ready stage, counting words accepted per output.
module demux_1_to_2_32bit_reg #(
   parameter int DATA_W = demux_1_to_2_32bit_reg_pkg::DATA_W,
   parameter int CNT_W  = demux_1_to_2_32bit_reg_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] a_data,
   output logic              a_valid,
   input  logic              a_ready,
   output logic [DATA_W-1:0] b_data,
   output logic              b_valid,
   input  logic              b_ready,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  a_count,
   output logic [CNT_W-1:0]  b_count
);
   import demux_1_to_2_32bit_reg_pkg::*;

   logic             a_free, b_free, load_a, load_b;
   logic [CNT_W-1:0] a_count_q, a_count_d, b_count_q, b_count_d;

   assign in_ready = (in_sel == SEL_B) ? b_free : a_free;
   assign load_a   = in_valid && in_ready && in_sel == SEL_A;
   assign load_b   = in_valid && in_ready && in_sel == SEL_B;

   demux_out_reg #(.W(DATA_W)) u_a (
      .clk(clk), .rst_n(rst_n), .load(load_a), .load_data(in_data),
      .x_ready(a_ready), .x_valid(a_valid), .x_data(a_data), .free(a_free)
   );

   demux_out_reg #(.W(DATA_W)) u_b (
      .clk(clk), .rst_n(rst_n), .load(load_b), .load_data(in_data),
      .x_ready(b_ready), .x_valid(b_valid), .x_data(b_data), .free(b_free)
   );

   // Clear first, then count, so a same-cycle accept lands as 1.
   always_comb begin
      a_count_d = (cnt_clr ? '0 : a_count_q) + {{(CNT_W-1){1'b0}}, load_a};
      b_count_d = (cnt_clr ? '0 : b_count_q) + {{(CNT_W-1){1'b0}}, load_b};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_count_q <= '0;
         b_count_q <= '0;
      end else begin
         a_count_q <= a_count_d;
         b_count_q <= b_count_d;
      end
   end

   assign a_count = a_count_q;
   assign b_count = b_count_q;
endmodule

// File: tb/tb_demux_1_to_2_32bit_reg.sv
// tb_demux_1_to_2_32bit_reg: directed and random stimulus scored against a
// queue-based model of the two output streams and their word counts.
module tb_demux_1_to_2_32bit_reg;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_sel, in_valid, in_ready;
   logic [31:0] a_data, b_data;
   logic        a_valid, a_ready, b_valid, b_ready, cnt_clr;
   logic [15:0] a_count, b_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] qa[$], qb[$];
   logic [15:0] ca, cb;

   always #5 clk = ~clk;

   demux_1_to_2_32bit_reg dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data),
      .a_valid(a_valid), .a_ready(a_ready), .b_data(b_data),
      .b_valid(b_valid), .b_ready(b_ready), .cnt_clr(cnt_clr),
      .a_count(a_count), .b_count(b_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: compare outputs against the model, advance the model by the
   // handshakes that happen at the coming edge, and return at the next negedge.
   task automatic tick();
      logic exp_rdy, acc;
      #1;
      exp_rdy = in_sel ? (qb.size() == 0 || b_ready) : (qa.size() == 0 || a_ready);
      check("in_ready", in_ready, exp_rdy);
      check("a_valid", a_valid, qa.size() != 0);
      check("b_valid", b_valid, qb.size() != 0);
      if (qa.size() != 0) check("a_data", a_data, qa[0]);
      if (qb.size() != 0) check("b_data", b_data, qb[0]);
      check("a_count", a_count, ca);
      check("b_count", b_count, cb);
      acc = in_valid && exp_rdy;
      if (qa.size() != 0 && a_ready) void'(qa.pop_front());
      if (qb.size() != 0 && b_ready) void'(qb.pop_front());
      if (cnt_clr) begin
         ca = 0;
         cb = 0;
      end
      if (acc && !in_sel) begin
         qa.push_back(in_data);
         ca = ca + 16'd1;
      end
      if (acc && in_sel) begin
         qb.push_back(in_data);
         cb = cb + 16'd1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic s, input logic [31:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 32'h11111111);
      a_ready = 1'b1;
      b_ready = 1'b1;
      cnt_clr = 1'b0;
      ca = 0;
      cb = 0;
      repeat (3) @(negedge clk);
      check("rst a_valid", a_valid, 0);
      check("rst b_valid", b_valid, 0);
      check("rst a_data", a_data, 0);
      check("rst b_data", b_data, 0);
      check("rst a_count", a_count, 0);
      check("rst b_count", b_count, 0);
      drive(1'b0, 1'b0, 32'h11111111);
      rst_n = 1'b1;
      #1 check("post-rst in_ready", in_ready, 1);
      tick();
      // route to A
      drive(1'b1, 1'b0, 32'h11111111);
      tick();
      check("A a_data", a_data, 32'h11111111);
      check("A a_count", a_count, 1);
      drive(1'b0, 1'b0, 32'h0);
      tick();
      // route to B with backpressure
      b_ready = 1'b0;
      drive(1'b1, 1'b1, 32'hAAAABBBB);
      tick();
      check("B b_data", b_data, 32'hAAAABBBB);
      drive(1'b1, 1'b1, 32'hFFFF0000);
      #1 check("B stall in_ready", in_ready, 0);
      tick();
      tick();
      check("B hold b_data", b_data, 32'hAAAABBBB);
      b_ready = 1'b1;
      tick();
      check("B refill b_data", b_data, 32'hFFFF0000);
      check("B b_count", b_count, 2);
      b_ready = 1'b0;
      drive(1'b0, 1'b1, 32'h0);
      tick();
      // A streams while B is stalled full
      drive(1'b1, 1'b0, 32'h000FF000);
      tick();
      check("ind a_data0", a_data, 32'h000FF000);
      drive(1'b1, 1'b0, 32'h00000001);
      tick();
      check("ind a_data1", a_data, 32'h00000001);
      check("ind b_data", b_data, 32'hFFFF0000);
      drive(1'b0, 1'b0, 32'h0);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      // counter wrap: 65535 accepts to A, then one more
      drive(1'b1, 1'b0, 32'h12345678);
      repeat (65535) @(posedge clk);
      @(negedge clk);
      qa.delete();
      qa.push_back(32'h12345678);
      ca = 16'hFFFF;
      check("wrap pre a_count", a_count, 16'hFFFF);
      tick();
      check("wrap a_count", a_count, 0);
      // clear with a same-cycle accept to B
      b_ready = 1'b1;
      cnt_clr = 1'b1;
      drive(1'b1, 1'b1, 32'hCAFEF00D);
      tick();
      cnt_clr = 1'b0;
      check("clr b_count", b_count, 1);
      check("clr a_count", a_count, 0);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom);
         a_ready = $urandom_range(0, 2) != 0;
         b_ready = $urandom_range(0, 2) != 0;
         cnt_clr = $urandom_range(0, 31) == 0;
         tick();
      end
      // async reset with both channels full
      cnt_clr = 1'b0;
      a_ready = 1'b0;
      b_ready = 1'b0;
      drive(1'b1, 1'b0, 32'h0BADF00D);
      tick();
      drive(1'b1, 1'b1, 32'h600DF00D);
      tick();
      drive(1'b0, 1'b0, 32'h0);
      check("pre-arst a_valid", a_valid, 1);
      check("pre-arst b_valid", b_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst a_valid", a_valid, 0);
      check("arst b_valid", b_valid, 0);
      check("arst a_count", a_count, 0);
      check("arst b_count", b_count, 0);
      qa.delete();
      qb.delete();
      ca = 0;
      cb = 0;
      @(negedge clk);
      rst_n = 1'b1;
      a_ready = 1'b1;
      b_ready = 1'b1;
      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/demux_1_to_2_32bit_reg.md
Name: demux_1_to_2_32bit_reg

Overview:
- Registered 1-to-2 demultiplexer/router with a valid/ready handshake on every port. It is the counterpart of the 2-to-1 32-bit mux.
- Steers each accepted 32-bit word from one input stream to output A (sel=0) or output B (sel=1).
- Sits on the datapath where one producer feeds two consumers, e.g. splitting a word stream between two processing lanes.
- Keeps a per-output count of accepted words for debug and bench checking.

Parameters:
- DATA_W, 32, width of the data word.
- CNT_W, 16, width of each per-output word counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  word offered by the producer.
- in_sel  input  1  destination select: 0 = output A, 1 = output B. Sampled together with in_data.
- in_valid  input  1  producer has a word on in_data/in_sel.
- in_ready  output  1  the block can accept the offered word this cycle.
- a_data  output  DATA_W  output A word.
- a_valid  output  1  output A holds a valid word.
- a_ready  input  1  consumer A accepts the word this cycle.
- b_data  output  DATA_W  output B word.
- b_valid  output  1  output B holds a valid word.
- b_ready  input  1  consumer B accepts the word this cycle.
- cnt_clr  input  1  synchronous clear of both counters.
- a_count  output  CNT_W  words accepted toward A.
- b_count  output  CNT_W  words accepted toward B.

Behaviour:
- Reset (rst_n low, asynchronous): a_valid=0, b_valid=0, a_data=0, b_data=0, a_count=0, b_count=0.
  - in_ready is combinational. It equals 0 while both channels are empty? No: after reset both channels are EMPTY, so in_ready=1.
- Each channel X (A or B) has one output register and a 2-state FSM:
  - EMPTY (x_valid=0) -> FULL on load.
  - FULL (x_valid=1) -> EMPTY when x_ready=1 and there is no load that cycle.
  - FULL -> FULL when x_ready=1 and a load occurs in the same cycle (drain and refill).
  - FULL -> FULL holding data when x_ready=0.
- Channel X is "free" this cycle when x_valid=0 or x_ready=1.
- in_ready = free(A) when in_sel=0, free(B) when in_sel=1. Combinational; it depends only on in_sel and the selected channel.
- Accept = in_valid & in_ready. On accept, in_data is written into the selected channel register at the next edge, and x_valid=1 from that edge.
  - Latency is 1 cycle.
  - Throughput is 1 word/cycle per channel when the consumer holds x_ready=1.
- The unselected channel is never modified by an accept. Its drain proceeds independently in the same cycle.
- x_data stays stable while x_valid=1 and x_ready=0. Data is never overwritten while the channel is FULL and not draining.
- in_valid=0: no load. in_sel and in_data are ignored.
- A stall on the selected channel never blocks reporting of the other channel. Only in_ready deasserts, and it reasserts as soon as in_sel points at a free channel.
- Counters:
  - x_count increments by 1 on each accept toward X.
  - Counters wrap from 2^CNT_W-1 to 0 with no saturation.
- cnt_clr=1 zeroes both counters. If an accept occurs in the same cycle, the target counter becomes 1 (clear, then count).
- Reset mid-transfer: all held words are dropped and valids cleared immediately (asynchronously); no partial state survives.

Decomposition:
- Shared package holds: DATA_W default 32; CNT_W default 16; SEL_A=1'b0, SEL_B=1'b1; channel state encoding EMPTY=1'b0, FULL=1'b1.
- One natural sub-module: demux_out_reg, a single-entry valid/ready output register. It has ports load, load_data, x_ready, x_valid, x_data and a free flag, and is instantiated twice (A and B).
- Counters stay in the top.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and data=0x11111111 -> a_valid=b_valid=0, counts=0. Release -> in_ready=1.
- Route to A: in_data=0x11111111, sel=0, valid=1 for one cycle, a_ready=1 -> next cycle a_data=0x11111111, a_valid=1, b_valid=0, a_count=1.
- Route to B with backpressure: in_data=0xAAAABBBB, sel=1, b_ready=0.
  - Next cycle b_valid=1 and b_data=0xAAAABBBB.
  - A second offer 0xFFFF0000 with sel=1 sees in_ready=0.
  - b_data stays 0xAAAABBBB while b_ready=0.
  - Raise b_ready -> 0xFFFF0000 loads the same cycle the old word drains; b_count=2.
- Independent channels: B stalled FULL (b_ready=0) while sel=0 words 0x000FF000 and 0x00000001 stream to A at 1/cycle -> a_data follows with 1-cycle latency, in_ready=1 throughout, b_data unchanged.
- Counter wrap and clear:
  - Preload via 65535 accepts to A -> a_count=0xFFFF; one more accept -> a_count=0x0000.
  - cnt_clr=1 together with an accept to B -> b_count=1, a_count=0.
- Async reset mid-stream: drop rst_n between edges while a_valid=b_valid=1 -> both valids 0 immediately without waiting for a clock edge; counts 0.
